usequencer_control: RTL and testbench

- Microprogrammed control unit that drives the ARC-style microarchitecture datapath. It is the controlling end of the datapath's control/status interface.
- Fetches 41-bit microwords from an external synchronous control-store ROM and holds the current one in the MIR.
- Drives the A/B/C field, mux-select and ALU-select inputs of the datapath, and handshakes RD/WR with data memory.
- Latches the datapath's active-low ALU flags into a PSR and computes the next microaddress with condition-branch logic (CBL) and opcode decode.

---
 rtl/usequencer_control.sv | 182 ++++++++++++++++++
 tb/tb_usequencer_control.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usequencer_control.sv
// Microprogrammed sequencer for the ARC-style datapath: fetches microwords into the MIR, drives
// the datapath control fields, handshakes data memory and computes the next microaddress.
// Optional build macro USEQ_RETIRE_COUNT_EN adds a retired-microinstruction counter output.
module usequencer_control #(
  parameter int DATAWIDTH_UADDR             = 11,
  parameter int DATAWIDTH_MIR               = 41,
  parameter int DATAWIDTH_BUS_REG_MIR_FIELD = 6,
  parameter int DATAWIDTH_ALU_SELECTION     = 4,
  parameter int DATAWIDTH_BUS_REG_IR_OP     = 8,
  parameter logic [DATAWIDTH_UADDR-1:0]             UADDR_RESET     = 11'd0,
  parameter logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] C_FIELD_NOWRITE = 6'd0
) (
  input  logic                                   uSequencer_CLOCK_50,
  input  logic                                   uSequencer_RESET_InLow,
  output logic [DATAWIDTH_UADDR-1:0]             uSequencer_ROM_Addr_Out,
  input  logic [DATAWIDTH_MIR-1:0]               uSequencer_ROM_Data_In,
  input  logic                                   uSequencer_Overflow_InLow,
  input  logic                                   uSequencer_Carry_InLow,
  input  logic                                   uSequencer_Negative_InLow,
  input  logic                                   uSequencer_Zero_InLow,
  input  logic                                   uSequencer_ALU_Flags_Write_PCR,
  input  logic [DATAWIDTH_BUS_REG_IR_OP-1:0]     uSequencer_Reg_IR_OP,
  input  logic                                   uSequencer_Reg_IR_IR13,
  output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSequencer_MUX_A_MIR,
  output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSequencer_MUX_B_MIR,
  output logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] uSequencer_MUX_C_MIR,
  output logic                                   uSequencer_MUX_A_MIR_Selector,
  output logic                                   uSequencer_MUX_B_MIR_Selector,
  output logic                                   uSequencer_MUX_C_MIR_Selector,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]     uSequencer_ALU_Selection_Out,
  output logic                                   uSequencer_DataMemory_Req_Out,
  output logic                                   uSequencer_DataMemory_WE_Out,
  input  logic                                   uSequencer_DataMemory_Ack_In,
  output logic                                   uSequencer_DataMemory_Selector_Out,
  output logic [3:0]                             uSequencer_PSR_Out
`ifdef USEQ_RETIRE_COUNT_EN
  ,
  output logic [31:0]                            uSequencer_Retire_Count_Out
`endif
);

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_EXEC, ST_MEM_WAIT} state_e;

  state_e                       state_q, state_d;
  logic [DATAWIDTH_UADDR-1:0]   upc_q, upc_d;
  logic [DATAWIDTH_UADDR-1:0]   naddr_q, naddr_d;
  logic [DATAWIDTH_MIR-1:0]     mir_q, mir_d;
  logic [3:0]                   psr_q, psr_d;

  logic [DATAWIDTH_BUS_REG_MIR_FIELD-1:0] mir_a, mir_b, mir_c;
  logic                                   mir_amux, mir_bmux, mir_cmux, mir_rd, mir_wr;
  logic [DATAWIDTH_ALU_SELECTION-1:0]     mir_alu;
  logic [2:0]                             mir_cond;
  logic [DATAWIDTH_UADDR-1:0]             mir_jaddr;
  logic [DATAWIDTH_UADDR-1:0]             seq_addr, target;
  logic [3:0]                             flags;
  logic                                   mem_op;

  assign mir_a     = mir_q[40:35];
  assign mir_amux  = mir_q[34];
  assign mir_b     = mir_q[33:28];
  assign mir_bmux  = mir_q[27];
  assign mir_c     = mir_q[26:21];
  assign mir_cmux  = mir_q[20];
  assign mir_rd    = mir_q[19];
  assign mir_wr    = mir_q[18];
  assign mir_alu   = mir_q[17:14];
  assign mir_cond  = mir_q[13:11];
  assign mir_jaddr = mir_q[10:0];
  assign mem_op    = mir_rd | mir_wr;

  // Flags arrive active low; the PSR stores {n,z,v,c} active high.
  assign flags = ~{uSequencer_Negative_InLow, uSequencer_Zero_InLow,
                   uSequencer_Overflow_InLow, uSequencer_Carry_InLow};

  assign seq_addr = upc_q + DATAWIDTH_UADDR'(1);

  always_comb begin
    case (mir_cond)
      3'd0:    target = seq_addr;
      3'd1:    target = psr_q[3] ? mir_jaddr : seq_addr;
      3'd2:    target = psr_q[2] ? mir_jaddr : seq_addr;
      3'd3:    target = psr_q[1] ? mir_jaddr : seq_addr;
      3'd4:    target = psr_q[0] ? mir_jaddr : seq_addr;
      3'd5:    target = uSequencer_Reg_IR_IR13 ? mir_jaddr : seq_addr;
      3'd6:    target = mir_jaddr;
      default: target = DATAWIDTH_UADDR'({1'b1, uSequencer_Reg_IR_OP, 2'b00});
    endcase
  end

  assign uSequencer_ROM_Addr_Out       = upc_q;
  assign uSequencer_MUX_A_MIR          = mir_a;
  assign uSequencer_MUX_B_MIR          = mir_b;
  assign uSequencer_MUX_A_MIR_Selector = mir_amux;
  assign uSequencer_MUX_B_MIR_Selector = mir_bmux;
  assign uSequencer_MUX_C_MIR_Selector = mir_cmux;
  assign uSequencer_ALU_Selection_Out  = mir_alu;
  assign uSequencer_PSR_Out            = psr_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    upc_d   = upc_q;
    naddr_d = naddr_q;
    mir_d   = mir_q;
    psr_d   = psr_q;
    uSequencer_MUX_C_MIR               = C_FIELD_NOWRITE;
    uSequencer_DataMemory_Req_Out      = 1'b0;
    uSequencer_DataMemory_WE_Out       = 1'b0;
    uSequencer_DataMemory_Selector_Out = 1'b0;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: begin
        mir_d   = uSequencer_ROM_Data_In;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (uSequencer_ALU_Flags_Write_PCR) psr_d = flags;
        if (mem_op) begin
          // Branch target is frozen here, before the PSR can change again in MEM_WAIT.
          uSequencer_DataMemory_Req_Out      = 1'b1;
          uSequencer_DataMemory_WE_Out       = mir_wr;
          uSequencer_DataMemory_Selector_Out = ~mir_wr;
          naddr_d = target;
          state_d = ST_MEM_WAIT;
        end else begin
          uSequencer_MUX_C_MIR = mir_c;
          upc_d   = target;
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WAIT: begin
        uSequencer_DataMemory_Req_Out      = 1'b1;
        uSequencer_DataMemory_WE_Out       = mir_wr;
        uSequencer_DataMemory_Selector_Out = ~mir_wr;
        if (uSequencer_DataMemory_Ack_In) begin
          if (!mir_wr) uSequencer_MUX_C_MIR = mir_c;
          if (uSequencer_ALU_Flags_Write_PCR) psr_d = flags;
          upc_d   = naddr_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge uSequencer_CLOCK_50) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!uSequencer_RESET_InLow) begin
      state_q <= ST_RST;
      upc_q   <= UADDR_RESET;
      naddr_q <= UADDR_RESET;
      mir_q   <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      naddr_q <= naddr_d;
      mir_q   <= mir_d;
      psr_q   <= psr_d;
    end
  end

`ifdef USEQ_RETIRE_COUNT_EN
  logic [31:0] retire_q, retire_d;
  logic        retire;

  assign retire = (state_q == ST_EXEC && !mem_op) ||
                  (state_q == ST_MEM_WAIT && uSequencer_DataMemory_Ack_In);
  assign retire_d = retire ? retire_q + 32'd1 : retire_q;
  assign uSequencer_Retire_Count_Out = retire_q;

  always_ff @(posedge uSequencer_CLOCK_50) begin
    if (!uSequencer_RESET_InLow) retire_q <= '0;
    else                         retire_q <= retire_d;
  end
`else
  // Retire counter not built.
`endif

endmodule

// File: tb/tb_usequencer_control.sv
// Self-checking bench for usequencer_control: microinstruction-level reference model compared
// every cycle, plus directed literal checks for reset, branches, decode, memory and wrap.
module tb_usequencer_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] rom_addr;
  logic [40:0] rom_data;
  logic        ovf_n, carry_n, neg_n, zero_n, fw;
  logic [7:0]  ir_op;
  logic        ir13;
  logic [5:0]  mux_a, mux_b, mux_c;
  logic        sel_a, sel_b, sel_c;
  logic [3:0]  alu;
  logic        req, we, ack, msel;
  logic [3:0]  psr;
  logic [31:0] retire;

  usequencer_control dut (
    .uSequencer_CLOCK_50               (clk),
    .uSequencer_RESET_InLow            (rst_n),
    .uSequencer_ROM_Addr_Out           (rom_addr),
    .uSequencer_ROM_Data_In            (rom_data),
    .uSequencer_Overflow_InLow         (ovf_n),
    .uSequencer_Carry_InLow            (carry_n),
    .uSequencer_Negative_InLow         (neg_n),
    .uSequencer_Zero_InLow             (zero_n),
    .uSequencer_ALU_Flags_Write_PCR    (fw),
    .uSequencer_Reg_IR_OP              (ir_op),
    .uSequencer_Reg_IR_IR13            (ir13),
    .uSequencer_MUX_A_MIR              (mux_a),
    .uSequencer_MUX_B_MIR              (mux_b),
    .uSequencer_MUX_C_MIR              (mux_c),
    .uSequencer_MUX_A_MIR_Selector     (sel_a),
    .uSequencer_MUX_B_MIR_Selector     (sel_b),
    .uSequencer_MUX_C_MIR_Selector     (sel_c),
    .uSequencer_ALU_Selection_Out      (alu),
    .uSequencer_DataMemory_Req_Out     (req),
    .uSequencer_DataMemory_WE_Out      (we),
    .uSequencer_DataMemory_Ack_In      (ack),
    .uSequencer_DataMemory_Selector_Out(msel),
    .uSequencer_PSR_Out                (psr)
`ifdef USEQ_RETIRE_COUNT_EN
    ,
    .uSequencer_Retire_Count_Out       (retire)
`endif
  );

`ifndef USEQ_RETIRE_COUNT_EN
  assign retire = 32'd0;
`endif

  // Control store: the address settles at the start of FETCH and the word is sampled at its end.
  logic [40:0] rom [0:2047];
  assign rom_data = rom[rom_addr];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [40:0] mk(input int a, input int amux, input int b, input int bmux,
                                     input int c, input int cmux, input int rd, input int wr,
                                     input int alu_f, input int cond, input int jaddr);
    return {a[5:0], amux[0], b[5:0], bmux[0], c[5:0], cmux[0], rd[0], wr[0],
            alu_f[3:0], cond[2:0], jaddr[10:0]};
  endfunction

  // Reference: next microaddress from the branch rules.
  function automatic logic [10:0] next_addr(input logic [40:0] w, input logic [10:0] pc,
                                            input logic [3:0] p, input logic i13,
                                            input logic [7:0] op);
    int          cond;
    logic [10:0] seq;
    cond = int'(w[13:11]);
    seq  = pc + 11'd1;
    if (cond == 0) return seq;
    if (cond <= 4) return p[4-cond] ? w[10:0] : seq;
    if (cond == 5) return i13 ? w[10:0] : seq;
    if (cond == 6) return w[10:0];
    return {1'b1, op, 2'b00};
  endfunction

  // Model: which cycle of the current microinstruction we are in (0 fetch, 1 exec, 2+ waiting).
  bit          m_boot;
  int          m_step;
  logic [10:0] m_pc, m_tgt;
  logic [40:0] m_mir;
  logic [3:0]  m_psr;
  logic [31:0] m_cnt;
  bit          m_done;

  initial forever begin
    @(posedge clk);
    m_done = 1'b0;
    if (!rst_n) begin
      m_boot = 1'b1; m_step = 0; m_pc = 11'd0; m_tgt = 11'd0;
      m_mir = '0; m_psr = 4'd0; m_cnt = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_step == 0) begin
      m_mir  = rom[m_pc];
      m_step = 1;
    end else if (m_step == 1) begin
      m_tgt = next_addr(m_mir, m_pc, m_psr, ir13, ir_op);
      if (fw) m_psr = ~{neg_n, zero_n, ovf_n, carry_n};
      if (m_mir[19] || m_mir[18]) m_step = 2;
      else m_done = 1'b1;
    end else if (ack) begin
      if (fw) m_psr = ~{neg_n, zero_n, ovf_n, carry_n};
      m_done = 1'b1;
    end else begin
      m_step++;
    end
    if (m_done) begin
      m_pc = m_tgt; m_step = 0; m_cnt++;
    end
  end

  logic [5:0] e_c;
  logic [2:0] e_mem;
  logic       e_wr, e_memop;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      e_wr    = m_mir[18];
      e_memop = m_mir[19] | m_mir[18];
      e_c     = 6'd0;
      e_mem   = 3'b000;
      if (!m_boot && m_step == 1) begin
        if (e_memop) e_mem = {1'b1, e_wr, ~e_wr};
        else e_c = m_mir[26:21];
      end else if (!m_boot && m_step >= 2) begin
        e_mem = {1'b1, e_wr, ~e_wr};
        if (!e_wr && ack) e_c = m_mir[26:21];
      end
      check("addr", rom_addr, m_pc);
      check("fields", {mux_a, sel_a, mux_b, sel_b, sel_c, alu},
            {m_mir[40:27], m_mir[20], m_mir[17:14]});
      check("c_field", mux_c, e_c);
      check("mem", {req, we, msel}, e_mem);
      check("psr", psr, m_psr);
`ifdef USEQ_RETIRE_COUNT_EN
      check("retire", retire, m_cnt);
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic next_exec();
    int n = 0;
    do begin cycle(); n++; end while (!(m_step == 1 && !m_boot) && n < 40);
    if (!(m_step == 1 && !m_boot)) check("exec_timeout", 1, 0);
  endtask

  task automatic next_fetch();
    int n = 0;
    do begin cycle(); n++; end while (!(m_step == 0 && !m_boot) && n < 40);
    if (!(m_step == 0 && !m_boot)) check("fetch_timeout", 1, 0);
    settle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  int req_cnt;

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = '0;
    rom[0]    = mk(1, 1, 2, 0, 3, 1, 0, 0, 5, 0, 0);
    rom[1]    = mk(0, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0);
    rom[2]    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 100);
    rom[3]    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 200);
    rom[100]  = mk(2, 0, 2, 0, 2, 0, 0, 0, 2, 0, 0);
    rom[101]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 300);
    rom[102]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    rom[1536] = mk(3, 0, 0, 1, 7, 1, 1, 0, 0, 6, 2047);
    rom[2047] = mk(5, 1, 5, 1, 6, 0, 0, 0, 3, 0, 0);
    rom[200]  = mk(4, 0, 5, 0, 9, 0, 1, 1, 0, 4, 400);
    rom[400]  = mk(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    rst_n = 1'b0; ovf_n = 1'b1; carry_n = 1'b1; neg_n = 1'b1; zero_n = 1'b1;
    fw = 1'b0; ir_op = 8'd0; ir13 = 1'b0; ack = 1'b0;

    cycle(); chk_en = 1'b1; cycle(); settle();
    check("rst_addr", rom_addr, 11'd0);
    check("rst_req", req, 1'b0);
    check("rst_psr", psr, 4'd0);
    check("rst_c", mux_c, 6'd0);
    rst_n = 1'b1;
    cycle(); settle();
    check("fetch0_addr", rom_addr, 11'd0);
    check("fetch0_c", mux_c, 6'd0);
    cycle(); settle();
    check("exec0_c", mux_c, 6'd3);
    check("exec0_alu", alu, 4'd5);
    check("exec0_a", mux_a, 6'd1);
    cycle(); settle();
    check("fetch1_addr", rom_addr, 11'd1);

    // Zero flag loaded in uinst 1, branch on z taken in uinst 2.
    next_exec(); zero_n = 1'b0; fw = 1'b1;
    next_fetch(); zero_n = 1'b1; fw = 1'b0;
    next_fetch();
    check("br_z_taken", rom_addr, 11'd100);
    check("br_z_psr", psr, 4'b0100);
`ifdef USEQ_RETIRE_COUNT_EN
    check("retire3", retire, 32'd3);
`endif
    next_exec(); fw = 1'b1;
    next_fetch(); fw = 1'b0;
    next_fetch();
    check("br_z_fall", rom_addr, 11'd102);
    ir_op = 8'b10_000000;
    next_fetch();
    check("decode", rom_addr, 11'd1536);

    // Read: Ack in the third wait cycle; only the Ack cycle may load flags.
    next_exec(); settle();
    req_cnt = int'(req);
    check("rd_exec_c", mux_c, 6'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      ack = (i == 3); fw = 1'b1;
      neg_n = (i == 1) ? 1'b0 : 1'b1;
      carry_n = (i == 3) ? 1'b0 : 1'b1;
      settle();
      req_cnt += int'(req);
      check("rd_sel", msel, 1'b1);
      check(i == 3 ? "rd_ack_c" : "rd_wait_c", mux_c, i == 3 ? 6'd7 : 6'd0);
    end
    cycle(); ack = 1'b0; fw = 1'b0; carry_n = 1'b1; neg_n = 1'b1; settle();
    check("rd_done_req", req, 1'b0);
    check("rd_req_cycles", req_cnt, 4);
    check("rd_next_addr", rom_addr, 11'd2047);
    check("rd_psr", psr, 4'b0001);
    next_fetch();
    check("upc_wrap", rom_addr, 11'd0);
    next_fetch(); next_fetch(); next_fetch();
    check("br_z_clear", rom_addr, 11'd3);
    ir13 = 1'b1;
    next_fetch(); ir13 = 1'b0;
    check("br_ir13", rom_addr, 11'd200);

    // RD+WR acts as a write; an Ack already present in EXEC is ignored.
    next_exec(); ack = 1'b1; settle();
    check("wr_exec_mem", {req, we, msel}, 3'b110);
    check("wr_exec_c", mux_c, 6'd0);
    cycle(); settle();
    check("wr_wait_req", req, 1'b1);
    check("wr_ack_c", mux_c, 6'd0);
    cycle(); ack = 1'b0; settle();
    check("br_c_taken", rom_addr, 11'd400);

    // Reset in the middle of a read wait; Ack during reset is ignored.
    next_exec(); cycle(); cycle();
    rst_n = 1'b0;
    cycle(); ack = 1'b1; settle();
    check("midrst_req", req, 1'b0);
    check("midrst_addr", rom_addr, 11'd0);
    check("midrst_psr", psr, 4'd0);
    cycle(); rst_n = 1'b1; settle();
    check("midrst_boot_addr", rom_addr, 11'd0);
    cycle(); ack = 1'b0; settle();
    check("midrst_fetch_addr", rom_addr, 11'd0);
    check("midrst_fetch_req", req, 1'b0);
    next_fetch();
    check("midrst_resume", rom_addr, 11'd1);
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
